// File: rtl/ssd_scan_decoder.sv
// rtl/ssd_scan_decoder.sv - recovers 4-digit BCD frames from a scanned 7-segment display bus (optional SSD_DEC_SYNC_EN input synchroniser)
module ssd_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] bcd,
    output logic [3:0]  blank,
    output logic [3:0]  err,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        ovr
);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t      state, state_d;
    logic [3:0]  count, count_d;
    logic [10:0] smp, smp_q;
    logic [3:0]  an_lo;
    logic        onehot, changed, capture;
    logic [1:0]  idx;
    logic [5:0]  dec;
    logic [15:0] slot_bcd;
    logic [3:0]  slot_blank, slot_err, mask;
    logic        mask_full, accept, load, drop;

`ifdef SSD_DEC_SYNC_EN
    logic [10:0] sync1, sync2;

    // Two-flop synchroniser; idles at all ones (no digit selected, all segments dark)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {an, seg};
            sync2 <= sync1;
        end
    end
    assign smp = sync2;
`else
    assign smp = {an, seg};
`endif

    // Segment pattern to {digit value, blank, illegal}
    function automatic logic [5:0] decode(input logic [6:0] s);
        case (s)
            7'b0000001: decode = {4'h0, 2'b00};
            7'b1001111: decode = {4'h1, 2'b00};
            7'b0010010: decode = {4'h2, 2'b00};
            7'b0000110: decode = {4'h3, 2'b00};
            7'b1001100: decode = {4'h4, 2'b00};
            7'b0100100: decode = {4'h5, 2'b00};
            7'b0100000: decode = {4'h6, 2'b00};
            7'b0001111: decode = {4'h7, 2'b00};
            7'b0000000: decode = {4'h8, 2'b00};
            7'b0000100: decode = {4'h9, 2'b00};
            7'b1111111: decode = {4'hF, 2'b10};
            default:    decode = {4'hE, 2'b01};
        endcase
    endfunction

    assign an_lo   = ~smp[10:7];
    assign onehot  = (an_lo != 4'b0000) && ((an_lo & (an_lo - 4'd1)) == 4'b0000);
    assign changed = (smp != smp_q);
    assign dec     = decode(smp[6:0]);

    // Digit index of the single active-low select line
    always_comb begin
        idx = 2'd0;
        case (an_lo)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    // Scan state, stability counter and previous sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= 4'd0;
            smp_q <= '1;
        end else begin
            state <= state_d;
            count <= count_d;
            smp_q <= smp;
        end
    end

    // Next state: a new one-hot sample restarts settling; capture once when stable long enough
    always_comb begin
        state_d = state;
        count_d = count;
        capture = 1'b0;
        if (!en || !onehot) begin
            state_d = IDLE;
            count_d = 4'd0;
        end else if (changed || state == IDLE) begin
            state_d = SETTLE;
            count_d = 4'd1;
        end else if (state == SETTLE) begin
            count_d = count + 4'd1;
            if (count_d == 4'(STABLE_CYCLES)) begin
                capture = 1'b1;
                state_d = HOLD;
            end
        end
    end

    // Per-digit slots; a recapture simply overwrites the slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_bcd   <= 16'h0000;
            slot_blank <= 4'b0000;
            slot_err   <= 4'b0000;
        end else if (capture) begin
            slot_bcd[{idx, 2'b00} +: 4] <= dec[5:2];
            slot_blank[idx]             <= dec[1];
            slot_err[idx]               <= dec[0];
        end
    end

    assign mask_full = (mask == 4'hF);
    assign accept    = frame_valid && frame_ready;
    assign load      = mask_full && (!frame_valid || accept);
    assign drop      = mask_full && frame_valid && !frame_ready;

    // Frame assembly, output register, handshake and sticky overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask        <= 4'b0000;
            bcd         <= 16'h0000;
            blank       <= 4'b0000;
            err         <= 4'b0000;
            frame_valid <= 1'b0;
            ovr         <= 1'b0;
        end else begin
            if (!en)
                mask <= 4'b0000;
            else
                mask <= (mask_full ? 4'b0000 : mask) | (capture ? (4'b0001 << idx) : 4'b0000);
            if (load) begin
                bcd         <= slot_bcd;
                blank       <= slot_blank;
                err         <= slot_err;
                frame_valid <= 1'b1;
            end else if (accept) begin
                frame_valid <= 1'b0;
            end
            if (drop)
                ovr <= 1'b1;
            else if (accept)
                ovr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// tb/tb_ssd_scan_decoder.sv - directed self-checking bench for ssd_scan_decoder
module tb_ssd_scan_decoder;

    localparam logic [6:0] S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100, S5 = 7'b0100100, S6 = 7'b0100000;
    localparam logic [6:0] S7 = 7'b0001111, S8 = 7'b0000000, S9 = 7'b0000100;
    localparam logic [6:0] S0 = 7'b0000001, SB = 7'b1111111, SX = 7'b1110000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic [3:0]  an = 4'b1111;
    logic [6:0]  seg = 7'b1111111;
    logic        frame_ready = 1'b1;
    logic [15:0] bcd;
    logic [3:0]  blank, err;
    logic        frame_valid, ovr;

    int total = 0;
    int passed = 0;
    int pulses = 0;
    int p0;
    logic fv_d = 1'b0;

    ssd_scan_decoder #(.STABLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .an(an), .seg(seg),
        .bcd(bcd), .blank(blank), .err(err), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .ovr(ovr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (frame_valid && !fv_d) pulses = pulses + 1;
        fv_d = frame_valid;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic show(input int i, input logic [6:0] s, input int n);
        an  = ~(4'b0001 << i);
        seg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic gap(input int n);
        an  = 4'b1111;
        seg = SB;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c, input logic [6:0] d);
        show(0, a, 4);
        show(1, b, 4);
        show(2, c, 4);
        show(3, d, 4);
        gap(6);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_bcd", bcd, 16'h0000);
        check("rst_blank", {12'h0, blank}, 16'h0);
        check("rst_err", {12'h0, err}, 16'h0);
        check("rst_fv", {15'h0, frame_valid}, 16'h0);
        check("rst_ovr", {15'h0, ovr}, 16'h0);
        rst_n = 1'b1;
        @(negedge clk);

        p0 = pulses;
        scan(S4, S2, S9, SB);
        check("basic_pulses", 16'(pulses - p0), 16'd1);
        check("basic_bcd", bcd, 16'hF924);
        check("basic_blank", {12'h0, blank}, 16'h0008);
        check("basic_err", {12'h0, err}, 16'h0);
        check("basic_fv_low", {15'h0, frame_valid}, 16'h0);

        scan(S1, SX, S8, S0);
        check("illegal_bcd", bcd, 16'h08E1);
        check("illegal_err", {12'h0, err}, 16'h0002);
        check("illegal_blank", {12'h0, blank}, 16'h0);

        p0 = pulses;
        show(0, S5, 4);
        an = 4'b1100; seg = S8;
        @(negedge clk);
        show(1, S6, 4);
        show(2, S7, 4);
        show(3, S3, 4);
        gap(6);
        check("glitch_pulses", 16'(pulses - p0), 16'd1);
        check("glitch_bcd", bcd, 16'h3765);
        check("glitch_err", {12'h0, err}, 16'h0);

        p0 = pulses;
        show(0, S1, 4);
        show(1, S1, 4);
        show(2, S1, 3);
        show(3, S1, 4);
        gap(6);
        check("short_no_frame", 16'(pulses - p0), 16'd0);
        show(2, S2, 4);
        gap(6);
        check("short_fill_pulses", 16'(pulses - p0), 16'd1);
        check("short_fill_bcd", bcd, 16'h1211);

        frame_ready = 1'b0;
        scan(S4, S2, S9, SB);
        check("hold_fv", {15'h0, frame_valid}, 16'h1);
        check("hold_ovr_clear", {15'h0, ovr}, 16'h0);
        scan(S1, SX, S8, S0);
        check("ovr_set", {15'h0, ovr}, 16'h1);
        check("ovr_fv", {15'h0, frame_valid}, 16'h1);
        check("ovr_first_kept", bcd, 16'hF924);
        check("ovr_first_blank", {12'h0, blank}, 16'h0008);
        frame_ready = 1'b1;
        @(negedge clk);
        check("accept_fv", {15'h0, frame_valid}, 16'h0);
        check("accept_ovr", {15'h0, ovr}, 16'h0);
        check("accept_bcd", bcd, 16'hF924);

        show(0, S7, 4);
        show(1, S7, 4);
        rst_n = 1'b0;
        #1;
        check("rst_mid_bcd", bcd, 16'h0000);
        check("rst_mid_blank", {12'h0, blank}, 16'h0);
        check("rst_mid_fv", {15'h0, frame_valid}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        gap(2);
        p0 = pulses;
        scan(S5, S6, S7, S3);
        check("rst_after_pulses", 16'(pulses - p0), 16'd1);
        check("rst_after_bcd", bcd, 16'h3765);

        en = 1'b0;
        p0 = pulses;
        scan(S4, S2, S9, SB);
        check("en_off_pulses", 16'(pulses - p0), 16'd0);
        check("en_off_bcd", bcd, 16'h3765);
        en = 1'b1;
        scan(S4, S2, S9, SB);
        check("en_on_pulses", 16'(pulses - p0), 16'd1);
        check("en_on_bcd", bcd, 16'hF924);
        check("en_on_blank", {12'h0, blank}, 16'h0008);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ssd_scan_decoder.md
SSD_SCAN_DECODER -- requirements
Module: ssd_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, giving the consecutive identical samples needed to accept a digit (legal range 2..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; every flop is rising-edge clocked.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port en, input, 1 bit: active-high capture enable.
REQ-005 SHALL have port an, input, 4 bits: active-low digit select of a scanned 4-digit display; bit i selects digit i.
REQ-006 SHALL have port seg, input, 7 bits: active-low segments {a,b,c,d,e,f,g}, with a at bit 6.
REQ-007 SHALL have port bcd, output, 16 bits: decoded frame; digit i is in bits [4i+3:4i].
REQ-008 SHALL have port blank, output, 4 bits: bit i set when digit i was dark in the frame.
REQ-009 SHALL have port err, output, 4 bits: bit i set when digit i showed an illegal pattern in the frame.
REQ-010 SHALL have port frame_valid, output, 1 bit: a frame is held on bcd, blank and err.
REQ-011 SHALL have port frame_ready, input, 1 bit: the consumer accepts the frame.
REQ-012 SHALL have port ovr, output, 1 bit: sticky flag, at least one completed frame was dropped.

Function
REQ-013 SHALL decode seg patterns to digit values as follows: 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9.
REQ-014 SHALL treat 1111111 as blank: digit value 4'hF, blank bit set.
REQ-015 SHALL treat any other seg pattern as illegal: digit value 4'hE, err bit set.
REQ-016 SHALL implement states IDLE, SETTLE and HOLD on the sampled {an,seg}; "sample" means the synchronised value when SSD_DEC_SYNC_EN is defined, otherwise the raw value.
REQ-017 SHALL enter IDLE whenever an is not one-hot-low (all high, or two or more low); no capture occurs in IDLE.
REQ-018 SHALL enter SETTLE with the stability count set to 1 when the sample changes to a one-hot-low an.
REQ-019 SHALL increment the stability count in SETTLE on each edge where the sample is unchanged.
REQ-020 SHALL, in SETTLE, capture the digit into slot i on the edge where the count reaches STABLE_CYCLES: set mask bit i and enter HOLD.
REQ-021 SHALL stay in HOLD while the sample is unchanged; any change SHALL leave HOLD per REQ-017 or REQ-018, and no re-capture occurs in HOLD.
REQ-022 SHALL overwrite slot i when digit i is recaptured before the frame completes.
REQ-023 SHALL, on the edge after the mask becomes 1111 with no frame pending (frame_valid low, or frame_valid and frame_ready both high), load bcd, blank and err from the slots, assert frame_valid and clear the mask.
REQ-024 SHALL, when the mask becomes 1111 while a frame is pending and not accepted that cycle, discard the new frame, clear the mask and set ovr.
REQ-025 SHALL deassert frame_valid on the edge where frame_valid and frame_ready are both high, unless REQ-023 reloads it on that same edge.
REQ-026 SHALL keep bcd, blank and err stable while frame_valid is high.
REQ-027 SHALL clear ovr only on an accepting handshake edge; a drop on that same edge SHALL keep ovr set.
REQ-028 SHALL, while en is low, force IDLE and clear the mask; the frame output and the handshake SHALL continue to operate.
REQ-029 SHALL have a latency from stable pins to slot capture of STABLE_CYCLES edges, plus 2 edges with the synchroniser.

Reset
REQ-030 SHALL, on rst_n low, asynchronously clear: bcd=16'h0000, blank=0, err=0, frame_valid=0, ovr=0, mask=0, state=IDLE, count=0, synchroniser flops to all ones.
REQ-031 SHALL discard any partial frame on reset mid-operation; capture SHALL restart from IDLE after rst_n rises.

Configuration
REQ-032 SHALL, with macro SSD_DEC_SYNC_EN defined, pass an and seg through a 2-flop synchroniser before sampling.
REQ-033 SHALL, without SSD_DEC_SYNC_EN, sample an and seg directly, so latency is 2 edges lower; all other behaviour SHALL be identical.

Verification
REQ-034 SHALL cover: scan digits 0..3 showing 4,2,9,blank with an held 4 cycles each, frame_ready=1 -> frame_valid pulses once, bcd=16'hF924, blank=4'b1000, err=0.
REQ-035 SHALL cover: seg=1110000 on digit 1 inside a full scan -> err=4'b0010, bcd[7:4]=4'hE.
REQ-036 SHALL cover: a 1-cycle glitch of an=1100 between digit slots -> no capture, no err, frame content unchanged.
REQ-037 SHALL cover: frame_ready=0 for two full scans, then 1 -> first frame retained, ovr=1 until the accepting edge, then 0.
REQ-038 SHALL cover: rst_n pulsed low after 2 digits are captured -> all outputs 0 immediately; the next full scan yields exactly one correct frame.
REQ-039 SHALL cover: en=0 during a full scan -> no frame_valid; en=1 -> normal capture resumes.
